// File: rtl/apb_slave_responder.sv
// APB3 slave responder: register bank, programmable wait states, PSLVERR decode, protocol checks.
// Optional APB4 byte strobes are enabled with `define APB_SLAVE_RESPONDER_PSTRB_EN.
module apb_slave_responder #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    MAX_WAIT   = 15,
   localparam int                   WW         = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_SLAVE_RESPONDER_PSTRB_EN
   input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
   input  logic [WW-1:0]           wait_cfg,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr,
   output logic [15:0]             xfer_count,
   output logic                    proto_err
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(NBYTES);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] BANK_BYTES = ADDR_WIDTH'(DEPTH * NBYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NBYTES - 1);
   localparam logic [WW-1:0]         WAIT_MAX   = WW'(MAX_WAIT);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic                  lat_write;
   logic [DATA_WIDTH-1:0] lat_wdata;
`ifdef APB_SLAVE_RESPONDER_PSTRB_EN
   logic [NBYTES-1:0]     lat_strb;
`endif
   logic [WW-1:0]         wait_cnt;
   logic [WW-1:0]         wait_sat;
   logic [DATA_WIDTH-1:0] bank [DEPTH];

   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      word_idx;
   logic                  dec_err;
   logic                  setup, complete, abort, ctrl_diff, idle_viol;

   assign wait_sat = (wait_cfg > WAIT_MAX) ? WAIT_MAX : wait_cfg;

   // Addresses below BASE_ADDR wrap to a huge offset and land in the range error.
   always_comb begin
      offset   = lat_addr - BASE_ADDR;
      word_idx = IDX_W'(offset >> OFF_W);
      dec_err  = (offset >= BANK_BYTES) || ((offset & ALIGN_MASK) != '0);
`ifdef APB_SLAVE_RESPONDER_PSTRB_EN
      if (!lat_write && (lat_strb != '0)) dec_err = 1'b1;
`endif
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      pready    = 1'b0;
      pslverr   = 1'b0;
      prdata    = '0;
      setup     = 1'b0;
      complete  = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (psel && !penable) begin
               setup     = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (!(psel && penable)) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == '0) begin
               complete  = 1'b1;
               pready    = 1'b1;
               pslverr   = dec_err;
               prdata    = (!dec_err && !lat_write) ? bank[word_idx] : '0;
               state_nxt = IDLE;
            end
         end
      endcase
   end

   // The transfer keeps running on the latched values even when the bus wanders.
   assign ctrl_diff = (state == ACCESS) && penable && ((paddr != lat_addr) || (pwrite != lat_write));
   assign idle_viol = (state == IDLE) && psel && penable;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         lat_addr   <= '0;
         lat_write  <= 1'b0;
         lat_wdata  <= '0;
`ifdef APB_SLAVE_RESPONDER_PSTRB_EN
         lat_strb   <= '0;
`endif
         wait_cnt   <= '0;
         xfer_count <= '0;
         proto_err  <= 1'b0;
         // NOTE: the bank is architecturally cleared by reset, so it must sit in flops, not a RAM macro.
         for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      end else begin
         if (setup) begin
            lat_addr  <= paddr;
            lat_write <= pwrite;
            lat_wdata <= pwdata;
`ifdef APB_SLAVE_RESPONDER_PSTRB_EN
            lat_strb  <= pstrb;
`endif
            wait_cnt  <= wait_sat;
         end else if ((state == ACCESS) && psel && penable && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - WW'(1);
         end

         if (complete) begin
            xfer_count <= xfer_count + 16'd1;
            if (lat_write && !dec_err) begin
`ifdef APB_SLAVE_RESPONDER_PSTRB_EN
               for (int b = 0; b < NBYTES; b++)
                  if (lat_strb[b]) bank[word_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
`else
               bank[word_idx] <= lat_wdata;
`endif
            end
         end

         if (abort || ctrl_diff || idle_viol) proto_err <= 1'b1;
      end
   end

endmodule

// File: doc/apb_slave_responder.md
# apb_slave_responder

Parametrised, synthesizable APB slave responder, the next generation of the slave-side driver BFM. It answers APB3 transfers (APB4 byte strobes optional) from a local register bank, with run-time programmable wait states, PSLVERR generation for bad addresses, and protocol-violation detection. It sits in the HDL top behind the slave agent and connects to the same `apb_if` signals the slave driver BFM drives.

## Interface

- `ADDR_WIDTH`, 32: PADDR width.
- `DATA_WIDTH`, 32: PWDATA/PRDATA width; must be 8, 16, 32 or 64.
- `DEPTH`, 16: number of DATA_WIDTH-bit words in the register bank; must be a power of two, ≥2.
- `BASE_ADDR`, 0: byte address of word 0; must be aligned to DEPTH*DATA_WIDTH/8.
- `MAX_WAIT`, 15: largest wait-state count accepted; WW = $clog2(MAX_WAIT+1).

- `pclk`  in  1  APB clock; all state updates on the rising edge.
- `preset`  in  1  reset, asynchronous, active-high.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH  byte address.
- `pwdata`  in  DATA_WIDTH  write data.
- `pstrb`  in  DATA_WIDTH/8  byte strobes; present only with APB_SLAVE_RESPONDER_PSTRB_EN.
- `wait_cfg`  in  WW  wait states for the next transfer, sampled in the setup cycle; values above MAX_WAIT saturate to MAX_WAIT.
- `prdata`  out  DATA_WIDTH  read data.
- `pready`  out  1  transfer completion.
- `pslverr`  out  1  transfer error.
- `xfer_count`  out  16  count of completed transfers.
- `proto_err`  out  1  sticky protocol-violation flag.

## Operation

- Reset: state IDLE; all bank words 0; `prdata`, `pready`, `pslverr` 0; `xfer_count` 0; `proto_err` 0. Reset asserted mid-transfer aborts it. Any pending write is discarded.
- FSM states: IDLE and ACCESS.
- IDLE → ACCESS: when `psel`=1 and `penable`=0 (setup cycle). On that edge, latch `paddr`, `pwrite`, `pwdata` and `pstrb`, and load the wait counter with the saturated `wait_cfg`.
- In ACCESS:
  - `psel`=1, `penable`=1, counter ≠ 0: decrement the counter; `pready`=0.
  - `psel`=1, `penable`=1, counter = 0: `pready`=1 (combinational from state and counter). The transfer completes on this edge and the FSM returns to IDLE.
  - `psel`=0: protocol violation. Set `proto_err`, return to IDLE, no bank update, no count.
  - Latched control differs from the live bus while `penable`=1: set `proto_err`. The latched values are used.
- In IDLE, `penable`=1 with `psel`=1 sets `proto_err`. No response is given.
- Decode:
  - offset = paddr − BASE_ADDR.
  - Error when offset ≥ DEPTH*DATA_WIDTH/8, or when paddr is not DATA_WIDTH/8-aligned.
  - Word index = offset >> log2(DATA_WIDTH/8).
- Completing write without error: the bank word is updated on the completion edge.
- Completing read without error: `prdata` = bank word during the `pready` cycle.
- Error transfer: `pslverr`=1 in the `pready` cycle, writes are dropped, `prdata`=0.
- Outside `pready` cycles, `prdata`=0 and `pslverr`=0.
- `xfer_count` increments on every completion edge, error or not. It wraps from 0xFFFF to 0.

## Timing

- Zero-wait transfer: setup cycle, then one access cycle with `pready`=1; 2 cycles total.
- With N wait states: N access cycles with `pready`=0, then one with `pready`=1; N+2 cycles total.
- Back-to-back: a setup cycle directly after the completion cycle is accepted. There is no idle gap.
- Read data is visible in the same cycle as `pready`; there is no extra pipeline stage.
- A write followed immediately by a read to the same address returns the new data.
- `wait_cfg` changes outside the setup cycle do not affect a transfer in flight.

## Configuration

- `APB_SLAVE_RESPONDER_PSTRB_EN` defined:
  - The `pstrb` port exists.
  - Writes update only the byte lanes whose strobe is 1.
  - A read with `pstrb` ≠ 0 completes with `pslverr`=1 and `prdata`=0.
- `APB_SLAVE_RESPONDER_PSTRB_EN` undefined:
  - There is no `pstrb` port.
  - Every write updates all byte lanes.

## Test plan

- Reset then zero-wait write 0xA5A5_0001 to 0x04, read 0x04 → `pready` in the 2nd cycle of each transfer, read returns 0xA5A5_0001, `xfer_count`=2, `pslverr`=0.
- `wait_cfg`=3, read 0x00 → `pready` low for 3 access cycles, high in the 4th; `prdata`=0 after reset.
- Write to 0x40 (DEPTH=16, 32-bit), then write to 0x02 (misaligned) → both give `pslverr`=1 with `pready`; no bank word changes; `xfer_count` advances by 2.
- `psel` dropped in the 2nd access cycle of a 3-wait write to 0x08 → `proto_err`=1, word 0x08 unchanged, `xfer_count` unchanged. The next clean transfer completes normally.
- With PSTRB_EN: write 0xFFFF_FFFF to 0x0C, then write 0x1234_5678 to 0x0C with `pstrb`=4'b0101 → read returns 0xFF34_FF78. A read with `pstrb`=4'b0001 gives `pslverr`=1.
- Assert `preset` during the wait phase of a write → outputs go to their reset values immediately, the write is dropped, all words read 0 afterwards.
